seg7_capture: RTL and testbench

SEG7_CAPTURE -- requirements
Module: seg7_capture

---
 rtl/seg7_pkg.sv | 39 +++
 rtl/seg7_lookup.sv | 28 ++
 rtl/seg7_capture.sv | 129 ++++++++++++
 tb/tb_seg7_capture.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// ============================================================================
// seg7_pkg : shared seven-segment constants, state enum and digit-select helpers
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

  localparam int SEG_W = 7;
  localparam int DIG_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Index is the hex value; entry is the lit pattern with seg[6]=a ... seg[0]=g.
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  function automatic logic is_onehot(input logic [DIG_N-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [1:0] pos_of(input logic [DIG_N-1:0] v);
    logic [1:0] p;
    p = '0;
    for (int i = 0; i < DIG_N; i++) begin
      if (v[i]) p = 2'(i);
    end
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_lookup.sv
// ============================================================================
// seg7_lookup : combinational segment pattern -> {hit, hex digit}
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module seg7_lookup
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic             hit,
  output logic [3:0]       digit
);

  always_comb begin
    hit   = 1'b0;
    digit = '0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        hit   = 1'b1;
        digit = 4'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg7_capture.sv
// ============================================================================
// seg7_capture : captures multiplexed 7-seg display strobes, decodes them to hex
//                digits with a valid/ready handshake and assembles a 4-digit frame.
//                Optional glitch check enabled by SEG7_CAPTURE_DEBOUNCE_EN.
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module seg7_capture
  import seg7_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEG_W-1:0] seg,
  input  logic [DIG_N-1:0] dig_sel,
  input  logic             strobe,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_digit,
  output logic [1:0]       out_pos,
  output logic             out_err,
  output logic [15:0]      frame,
  output logic             frame_done,
  output logic             overrun
);

`ifdef SEG7_CAPTURE_DEBOUNCE_EN
  localparam state_t AFTER_STROBE = ST_CHECK;
`else
  localparam state_t AFTER_STROBE = ST_HOLD;
`endif

  state_t           state, state_nx;
  logic [SEG_W-1:0] cap_seg;
  logic [DIG_N-1:0] cap_sel;
  logic [DIG_N-1:0] mask;
  logic             load, drop, accept;
  logic             hit, sel_ok;
  logic [3:0]       lut_digit;

  seg7_lookup u_lookup (
    .seg   (cap_seg),
    .hit   (hit),
    .digit (lut_digit)
  );

  // Outputs are decoded from the captured registers, so they stay frozen in HOLD.
  assign sel_ok    = is_onehot(cap_sel);
  assign out_valid = (state == ST_HOLD);
  assign out_err   = out_valid & ~(hit & sel_ok);
  assign out_digit = hit ? lut_digit : 4'd0;
  assign out_pos   = sel_ok ? pos_of(cap_sel) : 2'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    drop     = 1'b0;
    accept   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (strobe) begin
          load     = 1'b1;
          state_nx = AFTER_STROBE;
        end
      end
`ifdef SEG7_CAPTURE_DEBOUNCE_EN
      ST_CHECK: begin
        if (seg != cap_seg) begin
          drop     = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_HOLD;
        end
        if (strobe) drop = 1'b1;
      end
`endif
      ST_HOLD: begin
        if (out_ready) begin
          accept = 1'b1;
          // A strobe coinciding with the handshake starts the next capture directly.
          if (strobe) begin
            load     = 1'b1;
            state_nx = AFTER_STROBE;
          end else begin
            state_nx = ST_IDLE;
          end
        end else if (strobe) begin
          drop = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_seg    <= '0;
      cap_sel    <= '0;
      mask       <= '0;
      frame      <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= drop;
      if (load) begin
        cap_seg <= seg;
        cap_sel <= dig_sel;
      end
      if (accept && !out_err) begin
        frame[{out_pos, 2'b00} +: 4] <= out_digit;
        if ((mask | cap_sel) == 4'hF) begin
          mask       <= '0;
          frame_done <= 1'b1;
        end else begin
          mask <= mask | cap_sel;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_capture.sv
// ============================================================================
// tb_seg7_capture : directed table, corner sequences and random traffic against
//                   a cycle-level reference model of the capture/handshake rules.
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module tb_seg7_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = '0;
  logic [3:0]  dig_sel = '0;
  logic        strobe = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [3:0]  out_digit;
  logic [1:0]  out_pos;
  logic        out_err;
  logic [15:0] frame;
  logic        frame_done;
  logic        overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seg7_capture dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .strobe     (strobe),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_digit  (out_digit),
    .out_pos    (out_pos),
    .out_err    (out_err),
    .frame      (frame),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  logic [6:0] ref_tab [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // Reference model: a captured digit is either being checked, held, or absent.
  logic       m_hold = 1'b0;
  logic       m_chk  = 1'b0;
  logic [6:0] m_cap_seg = '0;
  logic [3:0] m_cap_sel = '0;
  logic [3:0] m_fr [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0] m_seen = '0;
  logic       e_fd = 1'b0;
  logic       e_ov = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic ref_decode(input logic [6:0] s, input logic [3:0] d,
                            output logic [3:0] dig, output logic [1:0] pos,
                            output logic err);
    logic found;
    found = 1'b0;
    dig   = 4'd0;
    pos   = 2'd0;
    for (int i = 0; i < 16; i++) begin
      if (ref_tab[i] == s) begin
        found = 1'b1;
        dig   = 4'(i);
      end
    end
    if ($countones(d) == 1) begin
      for (int i = 0; i < 4; i++) if (d[i]) pos = 2'(i);
    end
    err = !found || ($countones(d) != 1);
  endtask

  task automatic model_start();
    m_cap_seg = seg;
    m_cap_sel = dig_sel;
`ifdef SEG7_CAPTURE_DEBOUNCE_EN
    m_chk = 1'b1;
`else
    m_hold = 1'b1;
`endif
  endtask

  task automatic model_step();
    logic [3:0] d;
    logic [1:0] p;
    logic       e;
    e_fd = 1'b0;
    e_ov = 1'b0;
    if (!rst_n) begin
      m_hold = 1'b0;
      m_chk  = 1'b0;
      m_cap_seg = '0;
      m_cap_sel = '0;
      for (int i = 0; i < 4; i++) m_fr[i] = 4'd0;
      m_seen = '0;
      return;
    end
    if (m_hold) begin
      if (out_ready) begin
        ref_decode(m_cap_seg, m_cap_sel, d, p, e);
        if (!e) begin
          m_fr[p] = d;
          m_seen[p] = 1'b1;
          if (m_seen == 4'hF) begin
            e_fd = 1'b1;
            m_seen = '0;
          end
        end
        m_hold = 1'b0;
        if (strobe) model_start();
      end else if (strobe) begin
        e_ov = 1'b1;
      end
    end else if (m_chk) begin
      m_chk = 1'b0;
      if (seg != m_cap_seg) e_ov = 1'b1;
      else                  m_hold = 1'b1;
      if (strobe) e_ov = 1'b1;
    end else if (strobe) begin
      model_start();
    end
  endtask

  task automatic compare_all();
    logic [3:0] d;
    logic [1:0] p;
    logic       e;
    chk("valid", out_valid, m_hold);
    if (m_hold) begin
      ref_decode(m_cap_seg, m_cap_sel, d, p, e);
      chk("digit", out_digit, d);
      chk("pos", out_pos, p);
      chk("err", out_err, e);
    end else begin
      chk("err_idle", out_err, 1'b0);
    end
    chk("frame", frame, {m_fr[3], m_fr[2], m_fr[1], m_fr[0]});
    chk("frame_done", frame_done, e_fd);
    chk("overrun", overrun, e_ov);
  endtask

  // One clock: apply inputs, advance model, sample 1 time unit after the edge.
  task automatic cyc(input logic s, input logic [6:0] sg, input logic [3:0] ds, input logic rdy);
    strobe    = s;
    seg       = sg;
    dig_sel   = ds;
    out_ready = rdy;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic settle(input logic [6:0] sg, input logic [3:0] ds, input logic rdy);
`ifdef SEG7_CAPTURE_DEBOUNCE_EN
    cyc(1'b0, sg, ds, rdy);
`endif
  endtask

  typedef struct {
    logic [6:0] sg;
    logic [3:0] ds;
    logic [3:0] digit;
    logic [1:0] pos;
    logic       err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{7'h7E, 4'b0001, 4'd0, 2'd0, 1'b0};
    vecs[1] = '{7'h00, 4'b0001, 4'd0, 2'd0, 1'b1};
    vecs[2] = '{7'h30, 4'b0011, 4'd1, 2'd0, 1'b1};
    vecs[3] = '{7'h30, 4'b0001, 4'd1, 2'd0, 1'b0};
    vecs[4] = '{7'h6D, 4'b0010, 4'd2, 2'd1, 1'b0};
    vecs[5] = '{7'h79, 4'b0100, 4'd3, 2'd2, 1'b0};
    vecs[6] = '{7'h33, 4'b1000, 4'd4, 2'd3, 1'b0};

    @(posedge clk);
    #1;
    cyc(1'b0, 7'h00, 4'b0000, 1'b0);
    cyc(1'b1, 7'h7E, 4'b0001, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_digit", out_digit, 4'd0);
    chk("rst_pos", out_pos, 2'd0);
    chk("rst_frame", frame, 16'h0000);
    rst_n = 1'b1;
    cyc(1'b0, 7'h00, 4'b0000, 1'b0);

    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, vecs[i].sg, vecs[i].ds, 1'b1);
      settle(vecs[i].sg, vecs[i].ds, 1'b1);
      chk("tbl_valid", out_valid, 1'b1);
      chk("tbl_digit", out_digit, vecs[i].digit);
      chk("tbl_pos", out_pos, vecs[i].pos);
      chk("tbl_err", out_err, vecs[i].err);
      cyc(1'b0, 7'h00, 4'b0000, 1'b1);
    end
    chk("frame_4321", frame, 16'h4321);
    chk("frame_done_pulse", frame_done, 1'b1);
    cyc(1'b0, 7'h00, 4'b0000, 1'b0);
    chk("frame_done_once", frame_done, 1'b0);

    // Consumer stalls while a second strobe arrives.
    cyc(1'b1, 7'h5B, 4'b0100, 1'b0);
    settle(7'h5B, 4'b0100, 1'b0);
    cyc(1'b1, 7'h7F, 4'b0001, 1'b0);
    chk("ovr_pulse", overrun, 1'b1);
    chk("ovr_held_digit", out_digit, 4'd5);
    cyc(1'b0, 7'h7F, 4'b0001, 1'b0);
    chk("ovr_once", overrun, 1'b0);
    cyc(1'b0, 7'h7F, 4'b0001, 1'b0);
    chk("ovr_held_pos", out_pos, 2'd2);
    cyc(1'b0, 7'h00, 4'b0000, 1'b1);
    chk("ovr_delivered", frame[11:8], 4'd5);

    // Back-to-back: strobe during the handshake cycle.
    cyc(1'b1, 7'h77, 4'b0010, 1'b1);
    settle(7'h77, 4'b0010, 1'b1);
    cyc(1'b1, 7'h4F, 4'b1000, 1'b1);
    settle(7'h4F, 4'b1000, 1'b1);
    chk("b2b_digit", out_digit, 4'hE);
    cyc(1'b0, 7'h00, 4'b0000, 1'b1);

`ifdef SEG7_CAPTURE_DEBOUNCE_EN
    cyc(1'b1, 7'h7E, 4'b0001, 1'b1);
    cyc(1'b0, 7'h30, 4'b0001, 1'b1);
    chk("deb_glitch_valid", out_valid, 1'b0);
    chk("deb_glitch_ovr", overrun, 1'b1);
    cyc(1'b1, 7'h30, 4'b0001, 1'b1);
    chk("deb_lat1_valid", out_valid, 1'b0);
    cyc(1'b0, 7'h30, 4'b0001, 1'b1);
    chk("deb_lat2_digit", out_digit, 4'd1);
    cyc(1'b0, 7'h00, 4'b0000, 1'b1);
`endif

    // Reset with a digit pending.
    cyc(1'b1, 7'h70, 4'b0100, 1'b0);
    settle(7'h70, 4'b0100, 1'b0);
    rst_n = 1'b0;
    cyc(1'b0, 7'h70, 4'b0100, 1'b1);
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_frame", frame, 16'h0000);
    rst_n = 1'b1;
    cyc(1'b0, 7'h00, 4'b0000, 1'b1);
    chk("midrst_no_update", frame, 16'h0000);

    begin
      logic [6:0] rs;
      logic [3:0] rd;
      rs = 7'h7E;
      rd = 4'b0001;
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(0, 9) < 3) begin
          if ($urandom_range(0, 9) < 8) rs = ref_tab[$urandom_range(0, 15)];
          else                          rs = 7'($urandom);
          if ($urandom_range(0, 9) < 8) rd = 4'b0001 << $urandom_range(0, 3);
          else                          rd = 4'($urandom);
        end
        cyc(($urandom_range(0, 9) < 4), rs, rd, ($urandom_range(0, 9) < 6));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
